// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: debounces the board mode button and gaussian switch,
// keeps a pending filter configuration and applies it to the pixel pipeline
// only after camera configuration and only on a start-of-frame, holding a
// pipeline flush for a programmable number of settle frames.
// i_rstn asserts asynchronously; its release is expected to be synchronous
// to i_sysclk (from the board reset synchronizer).
module filter_mode_ctrl #(
    parameter logic [15:0] DB_CYCLES     = 16'd50000,
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic       i_sysclk,
    input  logic       i_rstn,
    input  logic       i_sof,
    input  logic       i_cfg_done,
    input  logic       i_btn_mode,
    input  logic       i_sw_gaussian,
    output logic [1:0] o_mode,
    output logic       o_gaussian_enable,
    output logic       o_pipe_flush,
    output logic       o_busy,
    output logic [7:0] o_status_leds
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SET_W = 4;
    localparam logic [1:0]       MODE_MAX    = 2'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0] DB_LAST     = DB_CYCLES - 16'd1;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'd0,
        S_ACTIVE   = 2'd1,
        S_FLUSH    = 2'd2,
        S_SETTLE   = 2'd3
    } state_t;

    // Bit 0 carries the mode button, bit 1 the gaussian switch.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            db_q;
    logic [1:0][CNT_W-1:0] db_cnt_q;
    logic                  btn_prev_q;
    logic                  btn_rise;

    logic [1:0]       pend_mode_q;
    logic             pend_gauss_q;
    logic             pend_diff;

    state_t           state_q;
    logic [SET_W-1:0] settle_q;
    logic [1:0]       mode_q;
    logic             gauss_q;
    logic             flush_q;
    logic             busy_q;
    logic             cfg_seen_q;

    // Two-flop synchronizers for the raw board inputs.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {i_sw_gaussian, i_btn_mode};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the output follows the input only after DB_CYCLES stable disagreeing cycles.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_rise  = db_q[0] & ~btn_prev_q;
    assign pend_diff = (pend_mode_q != mode_q) || (pend_gauss_q != gauss_q);

    // Pending configuration: button rising edge cycles the mode, switch level sets gaussian.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_prev_q   <= 1'b0;
            pend_mode_q  <= '0;
            pend_gauss_q <= 1'b0;
        end else begin
            btn_prev_q   <= db_q[0];
            pend_gauss_q <= db_q[1];
            if (btn_rise) begin
                pend_mode_q <= (pend_mode_q == MODE_MAX) ? 2'd0 : pend_mode_q + 2'd1;
            end
        end
    end

    // Apply scheduler: first config at cfg-done, later changes only on a flushed SOF.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_WAIT_CFG;
            settle_q   <= '0;
            mode_q     <= '0;
            gauss_q    <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            cfg_seen_q <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT_CFG: begin
                    busy_q  <= 1'b1;
                    flush_q <= 1'b0;
                    if (i_cfg_done) begin
                        mode_q     <= pend_mode_q;
                        gauss_q    <= pend_gauss_q;
                        cfg_seen_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (pend_diff) begin
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (i_sof) begin
                        mode_q   <= pend_mode_q;
                        gauss_q  <= pend_gauss_q;
                        settle_q <= SETTLE_INIT;
                        if (SETTLE_FRAMES == 0) begin
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_ACTIVE;
                        end else begin
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (i_sof) begin
                        settle_q <= settle_q - SET_W'(1);
                        if (settle_q == SET_W'(1)) begin
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_ACTIVE;
                        end
                    end
                end
                default: begin
                    state_q <= S_WAIT_CFG;
                end
            endcase
        end
    end

    assign o_mode            = mode_q;
    assign o_gaussian_enable = gauss_q;
    assign o_pipe_flush      = flush_q;
    assign o_busy            = busy_q;
    assign o_status_leds     = {pend_mode_q, cfg_seen_q, busy_q, flush_q, gauss_q, mode_q};

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: two instances (settle 2 and settle 0) share the
// stimulus and are compared every cycle against a frame-count reference model.
module tb_filter_mode_ctrl;

    localparam logic [15:0] DB = 16'd4;
    localparam int NM = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sof = 1'b0;
    logic cfg = 1'b0;
    logic btn = 1'b0;
    logic sw = 1'b0;

    logic [1:0] mode_a, mode_b;
    logic       g_a, g_b, fl_a, fl_b, busy_a, busy_b;
    logic [7:0] led_a, led_b;
    logic [12:0] obs_a, obs_b;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    filter_mode_ctrl #(.DB_CYCLES(DB), .NUM_MODES(NM), .SETTLE_FRAMES(2)) dut_a (
        .i_sysclk(clk), .i_rstn(rstn), .i_sof(sof), .i_cfg_done(cfg),
        .i_btn_mode(btn), .i_sw_gaussian(sw),
        .o_mode(mode_a), .o_gaussian_enable(g_a), .o_pipe_flush(fl_a),
        .o_busy(busy_a), .o_status_leds(led_a)
    );

    filter_mode_ctrl #(.DB_CYCLES(DB), .NUM_MODES(NM), .SETTLE_FRAMES(0)) dut_b (
        .i_sysclk(clk), .i_rstn(rstn), .i_sof(sof), .i_cfg_done(cfg),
        .i_btn_mode(btn), .i_sw_gaussian(sw),
        .o_mode(mode_b), .o_gaussian_enable(g_b), .o_pipe_flush(fl_b),
        .o_busy(busy_b), .o_status_leds(led_b)
    );

    assign obs_a = {led_a, mode_a, g_a, fl_a, busy_a};
    assign obs_b = {led_b, mode_b, g_b, fl_b, busy_b};

    // Reference model: shared input conditioning, per-instance frame tracker.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    int m_run [2];
    bit m_prev;
    int m_pmode;
    bit m_pg;
    int settle_of [2];
    bit m_cfgd [2];
    int m_amode [2];
    bit m_ag [2];
    int m_left [2];   // SOFs still needed to finish the current flush; 0 = none
    bit m_busy [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
            m_cfgd[i] = 0; m_amode[i] = 0; m_ag[i] = 0; m_left[i] = 0; m_busy[i] = 0;
        end
        m_prev = 0; m_pmode = 0; m_pg = 0;
    endtask

    task automatic model_edge();
        bit raw [2];
        int om;
        bit og;
        bit rise;
        raw[0] = btn; raw[1] = sw;
        om = m_pmode; og = m_pg;
        rise = m_db[0] && !m_prev;
        for (int k = 0; k < 2; k++) begin
            if (!m_cfgd[k]) begin
                if (cfg) begin
                    m_cfgd[k] = 1; m_amode[k] = om; m_ag[k] = og;
                end
            end else if (m_left[k] == 0) begin
                if (om != m_amode[k] || og != m_ag[k]) m_left[k] = settle_of[k] + 1;
            end else if (sof) begin
                if (m_left[k] == settle_of[k] + 1) begin
                    m_amode[k] = om; m_ag[k] = og;
                end
                m_left[k] = m_left[k] - 1;
            end
            m_busy[k] = !m_cfgd[k] || (m_left[k] > 0);
        end
        if (rise) m_pmode = (om == NM - 1) ? 0 : om + 1;
        m_pg = m_db[1];
        m_prev = m_db[0];
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] == m_db[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == int'(DB)) begin
                m_db[i] = m_s2[i]; m_run[i] = 0;
            end else m_run[i] = m_run[i] + 1;
        end
        for (int i = 0; i < 2; i++) begin
            m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
        end
    endtask

    function automatic logic [12:0] expv(int k);
        logic fl;
        logic [7:0] leds;
        fl = (m_left[k] > 0);
        leds = {2'(m_pmode), m_cfgd[k], m_busy[k], fl, m_ag[k], 2'(m_amode[k])};
        return {leds, 2'(m_amode[k]), m_ag[k], fl, m_busy[k]};
    endfunction

    // Advance one clock edge (model follows) and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_edge();
        #1;
    endtask

    // Reset then configure; leaves both instances in their active state.
    task automatic reinit();
        rstn = 1'b0; model_reset();
        step();
        rstn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cfg = (c == 12);
            step();
        end
        cfg = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            n_run++;
            if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_state a=%h b=%h required 0", obs_a, obs_b);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_cfg_done();
        bit seen_flush = 0;
        sw = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cfg = (c == 20);
            step();
            if (fl_a || fl_b) seen_flush = 1;
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL cfg_done c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
        end
        cfg = 1'b0;
        n_run++;
        if (g_a !== 1'b1 || busy_a !== 1'b0 || g_b !== 1'b1 || busy_b !== 1'b0 || seen_flush) begin
            n_fail++;
            $display("FAIL cfg_done_final gauss=%b/%b busy=%b/%b flush_seen=%0d required 1/1 0/0 0",
                     g_a, g_b, busy_a, busy_b, seen_flush);
        end
    endtask

    task automatic test_button_bounce();
        int changes = 0;
        logic [1:0] last_p;
        last_p = led_a[7:6];
        for (int c = 0; c < 80; c++) begin
            btn = (c == 0 || (c >= 2 && c < 13));
            sof = (c == 30 || c == 45 || c == 60);
            step();
            if (led_a[7:6] !== last_p) changes++;
            last_p = led_a[7:6];
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL button c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
            if (c == 29) begin
                n_run++;
                if (mode_a !== 2'd0 || fl_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL button_pre_sof mode=%0d flush=%b required 0 1", mode_a, fl_a);
                end
            end
            if (c == 30) begin
                n_run++;
                if (mode_a !== 2'd1 || mode_b !== 2'd1 || fl_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL button_sof mode=%0d/%0d flush_b=%b required 1/1 0", mode_a, mode_b, fl_b);
                end
            end
            if (c == 59 || c == 60) begin
                n_run++;
                if (fl_a !== (c == 59)) begin
                    n_fail++;
                    $display("FAIL settle_end c=%0d flush=%b required %b", c, fl_a, c == 59);
                end
            end
        end
        sof = 1'b0; btn = 1'b0;
        n_run++;
        if (changes != 1 || led_a[7:6] !== 2'd1) begin
            n_fail++;
            $display("FAIL pending_once changes=%0d pending=%0d required 1 1", changes, led_a[7:6]);
        end
    endtask

    task automatic test_mode_cycle();
        int exp_m;
        reinit();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 40; c++) begin
                btn = (c < 8);
                sof = (c == 20 || c == 26 || c == 32);
                step();
                n_run++;
                if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                    n_fail++;
                    $display("FAIL mode_cycle p=%0d c=%0d a=%h exp %h b=%h exp %h", p, c, obs_a, expv(0), obs_b, expv(1));
                end
            end
            case (p)
                0: exp_m = 1;
                1: exp_m = 2;
                2: exp_m = 0;
                default: exp_m = 1;
            endcase
            n_run++;
            if (mode_a !== 2'(exp_m) || mode_b !== 2'(exp_m) || fl_a || fl_b) begin
                n_fail++;
                $display("FAIL mode_seq p=%0d mode=%0d/%0d flush=%b/%b required %0d 0", p, mode_a, mode_b, fl_a, fl_b, exp_m);
            end
        end
        sof = 1'b0; btn = 1'b0;
    endtask

    task automatic test_toggle_flush();
        int rises_a = 0;
        int rises_b = 0;
        logic pa, pb;
        logic sw_new;
        pa = fl_a; pb = fl_b;
        sw_new = ~sw;
        for (int c = 0; c < 120; c++) begin
            btn = (c < 8);
            if (c == 12) sw = sw_new;
            if (c == 50) sw = ~sw_new;
            sof = (c == 30 || c == 40 || c == 70 || c == 90 || c == 100 || c == 110);
            step();
            if (fl_a && !pa) rises_a++;
            if (fl_b && !pb) rises_b++;
            pa = fl_a; pb = fl_b;
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL toggle c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
            if (c == 30) begin
                n_run++;
                if (mode_a !== 2'd2 || g_a !== sw_new || mode_b !== 2'd2 || g_b !== sw_new) begin
                    n_fail++;
                    $display("FAIL toggle_joint mode=%0d/%0d gauss=%b/%b required 2 %b", mode_a, mode_b, g_a, g_b, sw_new);
                end
            end
        end
        sof = 1'b0;
        n_run++;
        if (rises_a != 2 || rises_b != 2 || g_a !== ~sw_new || fl_a || fl_b) begin
            n_fail++;
            $display("FAIL toggle_second rises=%0d/%0d gauss=%b flush=%b/%b required 2/2 %b 0",
                     rises_a, rises_b, g_a, fl_a, fl_b, ~sw_new);
        end
    endtask

    task automatic test_settle_zero();
        for (int c = 0; c < 40; c++) begin
            btn = (c < 8);
            sof = (c == 25);
            step();
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL settle0 c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
            if (c == 24 || c == 25) begin
                n_run++;
                if (fl_b !== (c == 24) || busy_b !== (c == 24)) begin
                    n_fail++;
                    $display("FAIL settle0_edge c=%0d flush=%b busy=%b required %b", c, fl_b, busy_b, c == 24);
                end
            end
        end
        sof = 1'b0; btn = 1'b0;
        n_run++;
        if (mode_b !== 2'd0 || mode_a !== 2'd0 || fl_a !== 1'b1) begin
            n_fail++;
            $display("FAIL settle0_final mode=%0d/%0d flush_a=%b required 0/0 1", mode_a, mode_b, fl_a);
        end
    endtask

    task automatic test_reset_mid_settle();
        bit bad = 0;
        n_run++;
        if (fl_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset flush=%b busy=%b required 1 1", fl_a, busy_a);
        end
        #2;
        rstn = 1'b0; model_reset();
        #1;
        n_run++;
        if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset a=%h b=%h required 0", obs_a, obs_b);
        end
        step();
        step();
        rstn = 1'b1;
        for (int c = 0; c < 80; c++) begin
            btn = (c >= 10 && c < 18) || (c >= 40 && c < 48);
            if (c == 25) sw = ~sw;
            sof = (c % 10 == 5);
            step();
            if (fl_a || fl_b || mode_a != 2'd0 || g_a || mode_b != 2'd0 || g_b) bad = 1;
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL post_reset c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
        end
        sof = 1'b0; btn = 1'b0;
        n_run++;
        if (bad || busy_a !== 1'b1 || led_a[7:6] !== 2'd2) begin
            n_fail++;
            $display("FAIL no_apply_before_cfg applied_change=%0d busy=%b pending=%0d required 0 1 2",
                     bad, busy_a, led_a[7:6]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 14) == 0) btn = ~btn;
            if ($urandom_range(0, 24) == 0) sw = ~sw;
            sof = ($urandom_range(0, 11) == 0);
            cfg = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) begin
                rstn = 1'b0; model_reset();
            end else begin
                rstn = 1'b1;
            end
            step();
            n_run++;
            if (obs_a !== expv(0) || obs_b !== expv(1)) begin
                n_fail++;
                $display("FAIL random c=%0d a=%h exp %h b=%h exp %h", c, obs_a, expv(0), obs_b, expv(1));
            end
        end
        rstn = 1'b1; sof = 1'b0; cfg = 1'b0;
    endtask

    initial begin
        settle_of[0] = 2;
        settle_of[1] = 0;
        model_reset();
        test_reset();
        test_cfg_done();
        test_button_bounce();
        test_mode_cycle();
        test_toggle_flush();
        test_settle_zero();
        test_reset_mid_settle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
